// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Access-size codes follow the RISC-V load/store funct3 encoding.
package lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } lsu_state_e;

    // Byte-lane enables for an access of the given size at addr[1:0].
    function automatic logic [3:0] be_gen(
        input logic [2:0] size,
        input logic [1:0] addr
    );
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            LDST_B,
            LDST_BU: be = 4'b0001 << addr;
            LDST_H,
            LDST_HU: be = 4'b0011 << addr;
            LDST_W:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side and memory-side signals of the load/store unit.
// slave: the LSU itself; master: the core plus memory around it.
interface lsu_if;

    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    modport slave (
        input  core_req_i,
        input  core_we_i,
        input  core_size_i,
        input  core_addr_i,
        input  core_wd_i,
        output core_rd_o,
        output core_stall_o,
        output err_o,
        output mem_req_o,
        output mem_we_o,
        output mem_be_o,
        output mem_addr_o,
        output mem_wd_o,
        input  mem_rd_i,
        input  mem_ready_i
    );

    modport master (
        output core_req_i,
        output core_we_i,
        output core_size_i,
        output core_addr_i,
        output core_wd_i,
        input  core_rd_o,
        input  core_stall_o,
        input  err_o,
        input  mem_req_o,
        input  mem_we_o,
        input  mem_be_o,
        input  mem_addr_o,
        input  mem_wd_o,
        output mem_rd_i,
        output mem_ready_i
    );

endinterface

// File: rtl/lsu_rdata_extend.sv
// Selects the addressed byte/half of a memory word and extends it.
// Purely combinational so it can also sit on a cache read path.
module lsu_rdata_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  size_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;

    // Lane select then sign/zero extension by access size.
    always_comb begin
        byte_w   = word_i[{addr_i, 3'b000} +: 8];
        half_w   = word_i[{addr_i[1], 4'b0000} +: 16];
        result_o = 32'h0;
        case (size_i)
            LDST_B:  result_o = {{24{byte_w[7]}}, byte_w};
            LDST_BU: result_o = {24'h0, byte_w};
            LDST_H:  result_o = {{16{half_w[15]}}, half_w};
            LDST_HU: result_o = {16'h0, half_w};
            LDST_W:  result_o = word_i;
            default: result_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory port of the core: stalls the core while a word-wide
// memory access runs, then returns the extended load result.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic  clk_i,
    input logic  rst_i,
    lsu_if.slave bus
);

    localparam int unsigned TW =
        (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

    lsu_state_e  state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic        legal;
    logic        tmo_hit;
    logic [31:0] ext_rd;
    logic [31:0] wd_rep;

    logic        stall;
    logic        err;
    logic [31:0] core_rd;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;

    lsu_rdata_extend u_ext (
        .word_i   (bus.mem_rd_i),
        .addr_i   (bus.core_addr_i[1:0]),
        .size_i   (bus.core_size_i),
        .result_o (ext_rd)
    );

    // Alignment and size legality; stores have no unsigned variants.
    always_comb begin
        legal = 1'b0;
        case (bus.core_size_i)
            LDST_B:  legal = 1'b1;
            LDST_BU: legal = !bus.core_we_i;
            LDST_H:  legal = !bus.core_addr_i[0];
            LDST_HU: legal = !bus.core_we_i && !bus.core_addr_i[0];
            LDST_W:  legal = (bus.core_addr_i[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    // Replicate store data so every enabled lane carries it.
    always_comb begin
        wd_rep = bus.core_wd_i;
        case (bus.core_size_i)
            LDST_B,
            LDST_BU: wd_rep = {4{bus.core_wd_i[7:0]}};
            LDST_H,
            LDST_HU: wd_rep = {2{bus.core_wd_i[15:0]}};
            default: wd_rep = bus.core_wd_i;
        endcase
    end

    assign tmo_hit = TMO_EN && (tmo_q == TMO_LAST);

    // State, load-result and watchdog registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rdata_q <= 32'h0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next state plus all core/memory outputs for the current state.
    always_comb begin
        state_d  = state_q;
        rdata_d  = rdata_q;
        tmo_d    = tmo_q;
        stall    = 1'b0;
        err      = 1'b0;
        core_rd  = 32'h0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_be   = 4'b0000;
        mem_addr = 32'h0;
        mem_wd   = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (bus.core_req_i) begin
                    stall = 1'b1;
                    if (legal) begin
                        state_d = BUSY;
                        tmo_d   = '0;
                    end else begin
                        err     = 1'b1;
                        rdata_d = 32'h0;
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_we   = bus.core_we_i;
                mem_be   = be_gen(bus.core_size_i,
                                  bus.core_addr_i[1:0]);
                mem_addr = {bus.core_addr_i[31:2], 2'b00};
                mem_wd   = wd_rep;
                if (TMO_EN && (tmo_q != '1)) begin
                    tmo_d = tmo_q + TW'(1);
                end
                if (bus.mem_ready_i) begin
                    rdata_d = bus.core_we_i ? 32'h0 : ext_rd;
                    state_d = DONE;
                end else if (tmo_hit) begin
                    err     = 1'b1;
                    rdata_d = 32'h0;
                    state_d = DONE;
                end
            end
            DONE: begin
                core_rd = rdata_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.core_stall_o = stall;
    assign bus.err_o        = err;
    assign bus.core_rd_o    = core_rd;
    assign bus.mem_req_o    = mem_req;
    assign bus.mem_we_o     = mem_we;
    assign bus.mem_be_o     = mem_be;
    assign bus.mem_addr_o   = mem_addr;
    assign bus.mem_wd_o     = mem_wd;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with a small
// memory responder that asserts ready in a chosen BUSY cycle.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] word;
        int          rc;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        int          exp_stall;
        int          exp_busy;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase.
    task automatic apply(input vec_t v, input string tag);
        int          stall_n;
        int          busy_n;
        logic        err_seen;
        logic        done;
        logic        we_bad;
        logic [31:0] rd_got;
        logic [3:0]  be_got;
        logic [31:0] wd_got;
        logic [31:0] addr_got;
        logic        we_got;
        stall_n  = 0;
        busy_n   = 0;
        err_seen = 1'b0;
        done     = 1'b0;
        we_bad   = 1'b0;
        rd_got   = 32'hx;
        be_got   = 4'h0;
        wd_got   = 32'h0;
        addr_got = 32'h0;
        we_got   = 1'b0;
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = v.we;
        bus.core_size_i = v.size;
        bus.core_addr_i = v.addr;
        bus.core_wd_i   = v.wd;
        bus.mem_ready_i = 1'b0;
        bus.mem_rd_i    = ~v.word;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (bus.err_o) err_seen = 1'b1;
            if (!bus.core_stall_o) begin
                done   = 1'b1;
                rd_got = bus.core_rd_o;
                if (bus.mem_req_o || bus.mem_we_o) we_bad = 1'b1;
                bus.mem_ready_i = 1'b0;
            end else begin
                stall_n++;
                if (bus.mem_req_o) begin
                    busy_n++;
                    if (busy_n == 1) begin
                        be_got   = bus.mem_be_o;
                        wd_got   = bus.mem_wd_o;
                        addr_got = bus.mem_addr_o;
                        we_got   = bus.mem_we_o;
                    end
                end else if (bus.mem_we_o) begin
                    we_bad = 1'b1;
                end
                bus.mem_ready_i = bus.mem_req_o && (busy_n == v.rc);
                bus.mem_rd_i = bus.mem_ready_i ? v.word : ~v.word;
            end
        end
        bus.mem_ready_i = 1'b0;
        check({tag, " release"}, done, 1'b1);
        check({tag, " stall"}, stall_n, v.exp_stall);
        check({tag, " busy"}, busy_n, v.exp_busy);
        check({tag, " err"}, err_seen, v.exp_err);
        check({tag, " rd"}, rd_got, v.exp_rd);
        check({tag, " we_out"}, we_bad, 1'b0);
        if (v.exp_busy > 0) begin
            check({tag, " be"}, be_got, v.exp_be);
            check({tag, " wd"}, wd_got, v.exp_wd);
            check({tag, " addr"}, addr_got, {v.addr[31:2], 2'b00});
            check({tag, " we"}, we_got, v.we);
        end
        @(posedge clk);
        #1;
        bus.core_req_i = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, " idle stall"}, bus.core_stall_o, 1'b0);
        check({tag, " idle req"}, bus.mem_req_o, 1'b0);
        @(posedge clk);
        #1;
    endtask

    vec_t sw_v;
    vec_t lw_v;

    initial begin
        //         we  size     addr          wd            word          rc err rd            be       wd            st bz
        vecs[0]  = '{1'b0, LDST_W,  32'h100, 32'h0,        32'hDEADBEEF, 1, 1'b0, 32'hDEADBEEF, 4'b1111, 32'h0,        2, 1};
        vecs[1]  = '{1'b0, LDST_B,  32'h103, 32'h0,        32'h80112233, 1, 1'b0, 32'hFFFFFF80, 4'b1000, 32'h0,        2, 1};
        vecs[2]  = '{1'b0, LDST_BU, 32'h103, 32'h0,        32'h80112233, 1, 1'b0, 32'h00000080, 4'b1000, 32'h0,        2, 1};
        vecs[3]  = '{1'b1, LDST_H,  32'h202, 32'h0000ABCD, 32'hFFFFFFFF, 2, 1'b0, 32'h0,        4'b1100, 32'hABCDABCD, 3, 2};
        vecs[4]  = '{1'b0, LDST_W,  32'h101, 32'h0,        32'h12345678, 1, 1'b1, 32'h0,        4'b0000, 32'h0,        1, 0};
        vecs[5]  = '{1'b0, LDST_H,  32'h102, 32'h0,        32'h80017FFF, 1, 1'b0, 32'hFFFF8001, 4'b1100, 32'h0,        2, 1};
        vecs[6]  = '{1'b0, LDST_HU, 32'h100, 32'h0,        32'h1234F00D, 1, 1'b0, 32'h0000F00D, 4'b0011, 32'h0,        2, 1};
        vecs[7]  = '{1'b0, LDST_H,  32'h101, 32'h0,        32'h1234F00D, 1, 1'b1, 32'h0,        4'b0000, 32'h0,        1, 0};
        vecs[8]  = '{1'b1, LDST_B,  32'h201, 32'h123456A5, 32'hFFFFFFFF, 1, 1'b0, 32'h0,        4'b0010, 32'hA5A5A5A5, 2, 1};
        vecs[9]  = '{1'b0, 3'd3,    32'h0,   32'h0,        32'h12345678, 1, 1'b1, 32'h0,        4'b0000, 32'h0,        1, 0};
        vecs[10] = '{1'b1, LDST_BU, 32'h0,   32'h000000FF, 32'h12345678, 1, 1'b1, 32'h0,        4'b0000, 32'h0,        1, 0};
        vecs[11] = '{1'b0, LDST_B,  32'h001, 32'h0,        32'h00007F00, 1, 1'b0, 32'h0000007F, 4'b0010, 32'h0,        2, 1};
        vecs[12] = '{1'b1, LDST_W,  32'h30C, 32'hCAFEF00D, 32'h55555555, 3, 1'b0, 32'h0,        4'b1111, 32'hCAFEF00D, 4, 3};
        vecs[13] = '{1'b0, LDST_W,  32'h400, 32'h0,        32'h77777777, 0, 1'b1, 32'h0,        4'b1111, 32'h0,        5, 4};
        vecs[14] = '{1'b0, LDST_W,  32'h104, 32'h0,        32'h01020304, 2, 1'b0, 32'h01020304, 4'b1111, 32'h0,        3, 2};
        vecs[15] = '{1'b0, LDST_HU, 32'h102, 32'h0,        32'h80017FFF, 1, 1'b0, 32'h00008001, 4'b1100, 32'h0,        2, 1};
        sw_v     = '{1'b1, LDST_W,  32'h600, 32'h11223344, 32'h0,        1, 1'b0, 32'h0,        4'b1111, 32'h11223344, 2, 1};
        lw_v     = '{1'b0, LDST_W,  32'h604, 32'h0,        32'h55667788, 3, 1'b0, 32'h55667788, 4'b1111, 32'h0,        4, 3};

        rst             = 1'b1;
        bus.core_req_i  = 1'b0;
        bus.core_we_i   = 1'b0;
        bus.core_size_i = 3'd0;
        bus.core_addr_i = 32'h0;
        bus.core_wd_i   = 32'h0;
        bus.mem_rd_i    = 32'h0;
        bus.mem_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst stall", bus.core_stall_o, 1'b0);
        check("rst err", bus.err_o, 1'b0);
        check("rst rd", bus.core_rd_o, 32'h0);
        check("rst mem_req", bus.mem_req_o, 1'b0);
        check("rst mem_we", bus.mem_we_o, 1'b0);
        check("rst be", bus.mem_be_o, 4'b0000);
        check("rst addr", bus.mem_addr_o, 32'h0);
        check("rst wd", bus.mem_wd_o, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("v%0d", i));
            idle_check($sformatf("v%0d", i));
        end

        // ready outside BUSY must not start anything
        bus.mem_ready_i = 1'b1;
        bus.mem_rd_i    = 32'hFFFFFFFF;
        @(negedge clk);
        check("stray ready stall", bus.core_stall_o, 1'b0);
        check("stray ready req", bus.mem_req_o, 1'b0);
        @(negedge clk);
        check("stray ready rd", bus.core_rd_o, 32'h0);
        check("stray ready err", bus.err_o, 1'b0);
        @(posedge clk);
        #1;
        bus.mem_ready_i = 1'b0;

        // back-to-back: SW then LW with ready in the 3rd BUSY cycle
        apply(sw_v, "b2b sw");
        apply(lw_v, "b2b lw");
        idle_check("b2b");

        // asynchronous reset while BUSY
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b0;
        bus.core_size_i = LDST_W;
        bus.core_addr_i = 32'h500;
        @(negedge clk);
        @(negedge clk);
        check("arst pre req", bus.mem_req_o, 1'b1);
        #1;
        bus.core_req_i = 1'b0;
        rst = 1'b1;
        #1;
        check("arst req", bus.mem_req_o, 1'b0);
        check("arst stall", bus.core_stall_o, 1'b0);
        check("arst err", bus.err_o, 1'b0);
        check("arst rd", bus.core_rd_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle_check("arst");
        apply(vecs[0], "arst recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
